// File: rtl/flash_arb_pkg.sv
// flash_arb_pkg: shared types for the flash SPI arbiter.
// Arbiter state encoding and owner index constants.
package flash_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN0,
    ST_OWN1,
    ST_GAP
  } arb_state_e;

  localparam logic OWNER0 = 1'b0;
  localparam logic OWNER1 = 1'b1;

endpackage

// File: rtl/flash_spi_arbiter_if.sv
// flash_spi_arbiter_if: request/grant, both master SPI ports and flash pins.
// slave = arbiter side, master = masters plus flash side.
interface flash_spi_arbiter_if;

  logic req0, req1;
  logic gnt0, gnt1;
  logic spi0_cs, spi0_sck, spi0_mosi, spi0_miso;
  logic spi1_cs, spi1_sck, spi1_mosi, spi1_miso;
  logic flash_csn, flash_clk, flash_mosi, flash_miso;
  logic busy, timeout;

  modport slave (
    input  req0, req1,
    input  spi0_cs, spi0_sck, spi0_mosi,
    input  spi1_cs, spi1_sck, spi1_mosi,
    input  flash_miso,
    output gnt0, gnt1,
    output spi0_miso, spi1_miso,
    output flash_csn, flash_clk, flash_mosi,
    output busy, timeout
  );

  modport master (
    output req0, req1,
    output spi0_cs, spi0_sck, spi0_mosi,
    output spi1_cs, spi1_sck, spi1_mosi,
    output flash_miso,
    input  gnt0, gnt1,
    input  spi0_miso, spi1_miso,
    input  flash_csn, flash_clk, flash_mosi,
    input  busy, timeout
  );

endinterface

// File: rtl/arb_cycle_counter.sv
// arb_cycle_counter: clearable up-counter that saturates at MAX.
// Ports: clk, rst_n (async low), clr (to 0), en (count up), count.
module arb_cycle_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (en && count_q != W'(MAX))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/flash_spi_arbiter.sv
// flash_spi_arbiter: shares one SPI flash between two masters.
// Ports: clk_48mhz, reset_n (async low), bus (req/gnt, SPI, flash pins).
module flash_spi_arbiter
  import flash_arb_pkg::*;
#(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input logic                clk_48mhz,
  input logic                reset_n,
  flash_spi_arbiter_if.slave bus
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       tmo_q, tmo_d;

  logic          own, own_req, own_cs;
  logic          rel, wd_fire, gap_done;
  logic          in_gap, wd_en, wd_clr;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] wd_cnt;

  assign own     = (state_q == ST_OWN0) ||
                   (state_q == ST_OWN1);
  assign own_req = (state_q == ST_OWN1) ?
                   bus.req1 : bus.req0;
  assign own_cs  = (state_q == ST_OWN1) ?
                   bus.spi1_cs : bus.spi0_cs;
  assign in_gap  = (state_q == ST_GAP);

  // Release only at a CS boundary, never mid-transfer.
  assign rel = own && !own_req && own_cs;

  // Watchdog counts idle (CS high) owned cycles; any CS low clears it.
  assign wd_en   = own && own_cs;
  assign wd_clr  = !wd_en;
  assign wd_fire = wd_en && own_req &&
                   (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

  assign gap_done = in_gap &&
                    (gap_cnt == GW'(GAP_CYCLES - 1));

  arb_cycle_counter #(.MAX(GAP_CYCLES)) u_gap (
    .clk   (clk_48mhz),
    .rst_n (reset_n),
    .clr   (!in_gap),
    .en    (in_gap),
    .count (gap_cnt)
  );

  arb_cycle_counter #(.MAX(TIMEOUT_CYCLES)) u_wd (
    .clk   (clk_48mhz),
    .rst_n (reset_n),
    .clr   (wd_clr),
    .en    (wd_en),
    .count (wd_cnt)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Under contention the previous owner yields.
        if (bus.req0 &&
            (!bus.req1 || last_q == OWNER1))
          state_d = ST_OWN0;
        else if (bus.req1)
          state_d = ST_OWN1;
      end
      ST_OWN0, ST_OWN1: begin
        if (rel || wd_fire) begin
          state_d = ST_GAP;
          last_d  = (state_q == ST_OWN1) ?
                    OWNER1 : OWNER0;
          tmo_d   = wd_fire;
        end
      end
      ST_GAP: begin
        if (gap_done)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      last_q  <= OWNER1;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
    end
  end

  // Pin mux straight from the state flop: zero added SPI latency.
  always_comb begin
    bus.flash_csn  = 1'b1;
    bus.flash_clk  = 1'b0;
    bus.flash_mosi = 1'b0;
    bus.spi0_miso  = 1'b1;
    bus.spi1_miso  = 1'b1;
    case (state_q)
      ST_OWN0: begin
        bus.flash_csn  = bus.spi0_cs;
        bus.flash_clk  = bus.spi0_sck;
        bus.flash_mosi = bus.spi0_mosi;
        bus.spi0_miso  = bus.flash_miso;
      end
      ST_OWN1: begin
        bus.flash_csn  = bus.spi1_cs;
        bus.flash_clk  = bus.spi1_sck;
        bus.flash_mosi = bus.spi1_mosi;
        bus.spi1_miso  = bus.flash_miso;
      end
      default: ;
    endcase
  end

  assign bus.gnt0    = (state_q == ST_OWN0);
  assign bus.gnt1    = (state_q == ST_OWN1);
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.timeout = tmo_q;

endmodule

// File: tb/tb_flash_spi_arbiter.sv
// tb_flash_spi_arbiter: directed scenarios plus randomized traffic
// checked against a rule-level arbitration model and a pin monitor.
module tb_flash_spi_arbiter;

  localparam int GAP = 4;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 0;

  flash_spi_arbiter_if bus();

  flash_spi_arbiter #(
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_48mhz (clk),
    .reset_n   (rst_n),
    .bus       (bus)
  );

  always #10 clk = ~clk;

  // Pin monitor: owner's pins reach the flash, otherwise parked.
  logic [4:0] mon_o, mon_w;
  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if (bus.gnt0 && bus.gnt1) begin
        bad++;
        $display("FAIL mutex: gnt0=%b gnt1=%b want not both",
                 bus.gnt0, bus.gnt1);
      end
      if (bus.gnt0)
        mon_w = {bus.spi0_cs, bus.spi0_sck, bus.spi0_mosi,
                 bus.flash_miso, 1'b1};
      else if (bus.gnt1)
        mon_w = {bus.spi1_cs, bus.spi1_sck, bus.spi1_mosi,
                 1'b1, bus.flash_miso};
      else
        mon_w = 5'b10011;
      mon_o = {bus.flash_csn, bus.flash_clk, bus.flash_mosi,
               bus.spi0_miso, bus.spi1_miso};
      total++;
      if (mon_o !== mon_w) begin
        bad++;
        $display("FAIL pins @%0t: got %b want %b",
                 $time, mon_o, mon_w);
      end
    end
  end

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs;
    bus.req0 = 0; bus.req1 = 0;
    bus.spi0_cs = 1; bus.spi0_sck = 0; bus.spi0_mosi = 0;
    bus.spi1_cs = 1; bus.spi1_sck = 0; bus.spi1_mosi = 0;
    bus.flash_miso = 0;
  endtask

  task automatic do_reset;
    idle_inputs;
    rst_n = 0;
    cyc; cyc;
    rst_n = 1;
    cyc;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (bus.busy && n < 40) begin
      cyc; n++;
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: busy=%b want 0", nm, bus.busy);
    end
  endtask

  task automatic test_reset;
    logic [8:0] o;
    idle_inputs;
    rst_n = 0;
    #5;
    o = {bus.gnt0, bus.gnt1, bus.busy, bus.timeout,
         bus.flash_csn, bus.flash_clk, bus.flash_mosi,
         bus.spi0_miso, bus.spi1_miso};
    total++;
    if (o !== 9'b0000_100_11) begin
      bad++;
      $display("FAIL reset: got %b want 000010011", o);
    end
    mon_en = 1;
    cyc; cyc;
    rst_n = 1;
    cyc; cyc;
    total++;
    if ({bus.gnt0, bus.gnt1, bus.busy} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle: got %b want 000",
               {bus.gnt0, bus.gnt1, bus.busy});
    end
  endtask

  task automatic test_jedec;
    logic [7:0] cmd = 8'h9F;
    logic [4:0] o, w;
    bus.req0 = 1;
    #1;
    total++;
    if (bus.gnt0 !== 1'b0) begin
      bad++;
      $display("FAIL jedec_early: gnt0=%b want 0", bus.gnt0);
    end
    cyc;
    total++;
    if ({bus.gnt0, bus.gnt1, bus.busy} !== 3'b101) begin
      bad++;
      $display("FAIL jedec_gnt: got %b want 101",
               {bus.gnt0, bus.gnt1, bus.busy});
    end
    bus.spi0_cs = 0;
    for (int i = 0; i < 32; i++) begin
      for (int h = 0; h < 2; h++) begin
        bus.spi0_sck = 1'(h);
        bus.spi0_mosi = (i < 8) ? cmd[7-i] : 1'b0;
        bus.flash_miso = 1'($urandom);
        bus.spi1_sck = 1'($urandom);
        bus.spi1_mosi = 1'($urandom);
        #1;
        o = {bus.flash_csn, bus.flash_clk, bus.flash_mosi,
             bus.spi0_miso, bus.spi1_miso};
        w = {1'b0, bus.spi0_sck, bus.spi0_mosi,
             bus.flash_miso, 1'b1};
        total++;
        if (o !== w) begin
          bad++;
          $display("FAIL jedec_mux bit%0d: got %b want %b",
                   i, o, w);
        end
        cyc;
      end
    end
    bus.spi0_sck = 0; bus.spi1_sck = 0;
    bus.spi0_cs = 1;
    bus.req0 = 0;
    cyc;
    total++;
    if ({bus.gnt0, bus.busy, bus.timeout} !== 3'b010) begin
      bad++;
      $display("FAIL jedec_rel: got %b want 010",
               {bus.gnt0, bus.busy, bus.timeout});
    end
    wait_idle("jedec");
  endtask

  task automatic test_tie;
    int n, park, gapc;
    do_reset;
    bus.req0 = 1; bus.req1 = 1;
    cyc;
    total++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      bad++;
      $display("FAIL tie_first: got %b want 10",
               {bus.gnt0, bus.gnt1});
    end
    bus.spi0_cs = 0;
    repeat (3) cyc;
    bus.spi0_cs = 1; bus.req0 = 0;
    n = 0; park = 0; gapc = 0;
    do begin
      cyc; n++;
      if (!bus.gnt0 && !bus.gnt1) begin
        park++;
        if (bus.busy) gapc++;
      end
    end while (!bus.gnt1 && n < 40);
    total++;
    if (bus.gnt1 !== 1'b1) begin
      bad++;
      $display("FAIL tie_second: gnt1=%b want 1", bus.gnt1);
    end
    total++;
    if (gapc != GAP) begin
      bad++;
      $display("FAIL tie_gap: got %0d want %0d", gapc, GAP);
    end
    total++;
    if (park != GAP + 1) begin
      bad++;
      $display("FAIL tie_park: got %0d want %0d",
               park, GAP + 1);
    end
    bus.req1 = 0;
    cyc;
    wait_idle("tie");
  endtask

  task automatic test_hold;
    int held = 0;
    bus.req0 = 1;
    cyc;
    bus.spi0_cs = 0;
    cyc;
    bus.req0 = 0;
    for (int i = 0; i < 10; i++) begin
      cyc;
      if (bus.gnt0 === 1'b1) held++;
    end
    total++;
    if (held != 10) begin
      bad++;
      $display("FAIL hold_cs: held %0d want 10", held);
    end
    bus.spi0_cs = 1;
    #1;
    total++;
    if (bus.gnt0 !== 1'b1) begin
      bad++;
      $display("FAIL hold_edge: gnt0=%b want 1", bus.gnt0);
    end
    cyc;
    total++;
    if ({bus.gnt0, bus.busy} !== 2'b01) begin
      bad++;
      $display("FAIL hold_rel: got %b want 01",
               {bus.gnt0, bus.busy});
    end
    wait_idle("hold");
  endtask

  task automatic test_timeout;
    int n, m;
    bit ok, early;
    bus.req1 = 1; bus.spi1_cs = 1;
    cyc;
    total++;
    if (bus.gnt1 !== 1'b1) begin
      bad++;
      $display("FAIL wd_gnt: gnt1=%b want 1", bus.gnt1);
    end
    n = 0; early = 0;
    while (bus.gnt1 && n < 40) begin
      if (bus.timeout) early = 1;
      cyc; n++;
    end
    total++;
    if (n != TMO || early) begin
      bad++;
      $display("FAIL wd_len: got %0d early=%b want %0d",
               n, early, TMO);
    end
    total++;
    if ({bus.gnt1, bus.timeout} !== 2'b01) begin
      bad++;
      $display("FAIL wd_pulse: got %b want 01",
               {bus.gnt1, bus.timeout});
    end
    cyc;
    m = 1;
    total++;
    if (bus.timeout !== 1'b0) begin
      bad++;
      $display("FAIL wd_width: timeout=%b want 0",
               bus.timeout);
    end
    while (!bus.gnt1 && m < 40) begin
      cyc; m++;
    end
    total++;
    if (!bus.gnt1 || m != GAP + 1) begin
      bad++;
      $display("FAIL wd_regrant: got %0d want %0d",
               m, GAP + 1);
    end
    ok = 1;
    for (int i = 0; i < 9; i++) begin
      cyc;
      if (!bus.gnt1 || bus.timeout) ok = 0;
    end
    bus.spi1_cs = 0;
    cyc;
    bus.spi1_cs = 1;
    for (int i = 0; i < 12; i++) begin
      cyc;
      if (!bus.gnt1 || bus.timeout) ok = 0;
    end
    bus.req1 = 0;
    cyc;
    total++;
    if (!ok || bus.gnt1 || bus.timeout) begin
      bad++;
      $display("FAIL wd_clear: ok=%b gnt1=%b tmo=%b want 100",
               ok, bus.gnt1, bus.timeout);
    end
    wait_idle("wd");
  endtask

  task automatic test_async_reset;
    logic [4:0] o;
    bus.req0 = 1;
    cyc;
    bus.spi0_cs = 0;
    for (int i = 0; i < 4; i++) begin
      bus.spi0_sck = ~bus.spi0_sck;
      cyc;
    end
    @(posedge clk);
    #3;
    bus.spi0_sck = 1;
    #1;
    total++;
    if ({bus.flash_csn, bus.flash_clk} !== 2'b01) begin
      bad++;
      $display("FAIL arst_pre: got %b want 01",
               {bus.flash_csn, bus.flash_clk});
    end
    rst_n = 0;
    #1;
    o = {bus.flash_csn, bus.flash_clk, bus.gnt0,
         bus.busy, bus.spi0_miso};
    total++;
    if (o !== 5'b10001) begin
      bad++;
      $display("FAIL arst_park: got %b want 10001", o);
    end
    idle_inputs;
    cyc;
    rst_n = 1;
    cyc;
  endtask

  task automatic test_alternate;
    int n, k, rem, cur, got;
    bit active;
    do_reset;
    bus.req0 = 1; bus.req1 = 1;
    n = 0; k = 0; active = 0; cur = 0; rem = 0;
    while (n < 6 && k < 600) begin
      cyc; k++;
      if (!active) begin
        bus.req0 = 1; bus.req1 = 1;
        if (bus.gnt0 || bus.gnt1) begin
          got = bus.gnt1 ? 1 : 0;
          total++;
          if (got != n % 2) begin
            bad++;
            $display("FAIL alt_owner txn%0d: got %0d want %0d",
                     n, got, n % 2);
          end
          active = 1; cur = got;
          rem = $urandom_range(2, 6);
          if (cur == 0) bus.spi0_cs = 0;
          else bus.spi1_cs = 0;
        end
      end else begin
        rem--;
        if (rem == 0) begin
          if (cur == 0) begin
            bus.spi0_cs = 1; bus.req0 = 0;
          end else begin
            bus.spi1_cs = 1; bus.req1 = 0;
          end
          active = 0; n++;
        end
      end
    end
    total++;
    if (n != 6) begin
      bad++;
      $display("FAIL alt_count: got %0d want 6", n);
    end
    bus.req0 = 0; bus.req1 = 0;
    cyc;
    wait_idle("alt");
  endtask

  task automatic test_random;
    logic rq[2], cs[2], sk[2], mo[2];
    bit pg[2], g[2], r[2], rl[2];
    int idle[2], left[2], waits[2];
    int last, ntx, k;
    bit stop;
    do_reset;
    last = 1; ntx = 0; k = 0; stop = 0;
    for (int i = 0; i < 2; i++) begin
      rq[i] = 0; cs[i] = 1; sk[i] = 0; mo[i] = 0;
      pg[i] = 0; rl[i] = 0; left[i] = 0; waits[i] = 0;
      idle[i] = $urandom_range(0, 5);
    end
    while (k < 700 &&
           (k < 400 || rq[0] || rq[1] || pg[0] || pg[1])) begin
      stop = (k >= 400);
      bus.req0 = rq[0]; bus.spi0_cs = cs[0];
      bus.spi0_sck = sk[0]; bus.spi0_mosi = mo[0];
      bus.req1 = rq[1]; bus.spi1_cs = cs[1];
      bus.spi1_sck = sk[1]; bus.spi1_mosi = mo[1];
      bus.flash_miso = 1'($urandom);
      r[0] = rq[0]; r[1] = rq[1];
      cyc; k++;
      g[0] = bus.gnt0; g[1] = bus.gnt1;
      for (int i = 0; i < 2; i++) begin
        if (g[i] && !pg[i]) begin
          total++;
          if (!r[i] || (r[0] && r[1] && i == last) ||
              waits[i] > 1) begin
            bad++;
            $display("FAIL rnd_grant m%0d: req=%b last=%0d waits=%0d",
                     i, r[i], last, waits[i]);
          end
          left[i] = $urandom_range(1, 8);
          cs[i] = 0; waits[i] = 0;
        end else if (!g[i] && pg[i]) begin
          total++;
          if (!rl[i]) begin
            bad++;
            $display("FAIL rnd_revoke m%0d: got drop want held", i);
          end
          last = i; rl[i] = 0; ntx++;
          idle[i] = $urandom_range(0, 6);
          if (rq[1-i] && !g[1-i]) waits[1-i]++;
        end else if (g[i] && !rl[i]) begin
          sk[i] = 1'($urandom); mo[i] = 1'($urandom);
          left[i]--;
          if (left[i] == 0) begin
            cs[i] = 1; sk[i] = 0; rq[i] = 0; rl[i] = 1;
          end
        end else if (!g[i] && !rq[i] && !stop) begin
          if (idle[i] == 0) rq[i] = 1;
          else idle[i]--;
        end
        pg[i] = g[i];
      end
    end
    total++;
    if (ntx < 10) begin
      bad++;
      $display("FAIL rnd_txns: got %0d want >=10", ntx);
    end
    idle_inputs;
    wait_idle("rnd");
  endtask

  initial begin
    test_reset;
    test_jedec;
    test_tie;
    test_hold;
    test_timeout;
    test_async_reset;
    test_alternate;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
